// File: rtl/d7s_pkg.sv
// Shared 7-segment definitions: segment codes, scan payload, decoder FSM states
// and the segment-to-nibble decode function.
package d7s_pkg;

   localparam int unsigned NUM_DIGITS = 3;
   localparam int unsigned SEG_W      = 7;
   localparam int unsigned NIB_W      = 4;
   localparam int unsigned DIG_W      = NUM_DIGITS * NIB_W;

   typedef logic [SEG_W-1:0] seg_t;

   // Segment codes, bit order {g,f,e,d,c,b,a}
   localparam seg_t SEG_0 = 7'h3F;
   localparam seg_t SEG_1 = 7'h06;
   localparam seg_t SEG_2 = 7'h5B;
   localparam seg_t SEG_3 = 7'h4F;
   localparam seg_t SEG_4 = 7'h66;
   localparam seg_t SEG_5 = 7'h6D;
   localparam seg_t SEG_6 = 7'h7D;
   localparam seg_t SEG_7 = 7'h07;
   localparam seg_t SEG_8 = 7'h7F;
   localparam seg_t SEG_9 = 7'h6F;
   localparam seg_t SEG_A = 7'h77;
   localparam seg_t SEG_B = 7'h7C;
   localparam seg_t SEG_C = 7'h39;
   localparam seg_t SEG_D = 7'h5E;
   localparam seg_t SEG_E = 7'h79;
   localparam seg_t SEG_F = 7'h71;

   typedef struct packed {
      logic [NUM_DIGITS-1:0] sel;
      seg_t                  seg;
   } scan_t;

   typedef enum logic {SETTLE, HELD} state_t;

   // Returns {valid, nibble}; valid is 0 for any pattern outside the table
   function automatic logic [NIB_W:0] seg2nib(input seg_t s);
      case (s)
         SEG_0:   seg2nib = 5'h10;
         SEG_1:   seg2nib = 5'h11;
         SEG_2:   seg2nib = 5'h12;
         SEG_3:   seg2nib = 5'h13;
         SEG_4:   seg2nib = 5'h14;
         SEG_5:   seg2nib = 5'h15;
         SEG_6:   seg2nib = 5'h16;
         SEG_7:   seg2nib = 5'h17;
         SEG_8:   seg2nib = 5'h18;
         SEG_9:   seg2nib = 5'h19;
         SEG_A:   seg2nib = 5'h1A;
         SEG_B:   seg2nib = 5'h1B;
         SEG_C:   seg2nib = 5'h1C;
         SEG_D:   seg2nib = 5'h1D;
         SEG_E:   seg2nib = 5'h1E;
         SEG_F:   seg2nib = 5'h1F;
         default: seg2nib = 5'h00;
      endcase
   endfunction

endpackage

// File: rtl/d7s_scan_decoder_sync2.sv
// Two-flop synchronizer for an asynchronous input bus.
module d7s_scan_decoder_sync2 #(
   parameter int unsigned WIDTH = 1
) (
   input  logic             clk,
   input  logic             rst,
   input  logic [WIDTH-1:0] d,
   output logic [WIDTH-1:0] q
);

   logic [WIDTH-1:0] meta;

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         meta <= '0;
         q    <= '0;
      end else begin
         meta <= d;
         q    <= meta;
      end
   end

endmodule

// File: rtl/d7s_scan_decoder.sv
// Receive side of a scanned 7-segment display: captures each stable
// {dig_sel, seg} value once and rebuilds the three displayed hex digits.
module d7s_scan_decoder
   import d7s_pkg::*;
#(
   parameter int unsigned STABLE_CYCLES  = 4,
   parameter int unsigned TIMEOUT_CYCLES = 65535
) (
   input  logic                  clk,
   input  logic                  rst,
   input  logic [SEG_W-1:0]      seg_in,
   input  logic [NUM_DIGITS-1:0] dig_sel_in,
   input  logic                  err_clr,
   output logic [DIG_W-1:0]      digits,
   output logic [NUM_DIGITS-1:0] digit_valid,
   output logic                  frame_done,
   output logic                  pattern_err,
   output logic                  sel_err,
   output logic                  link_lost
);

   localparam int unsigned SCNT_W = $clog2(STABLE_CYCLES + 1);
   localparam int unsigned TCNT_W = $clog2(TIMEOUT_CYCLES + 1);
   localparam logic [SCNT_W-1:0] SCNT_MAX = SCNT_W'(STABLE_CYCLES);
   localparam logic [SCNT_W-1:0] SCNT_HIT = SCNT_W'(STABLE_CYCLES - 1);
   localparam logic [TCNT_W-1:0] TCNT_MAX = TCNT_W'(TIMEOUT_CYCLES);
   localparam logic [TCNT_W-1:0] TCNT_HIT = TCNT_W'(TIMEOUT_CYCLES - 1);
   localparam logic [NUM_DIGITS-1:0] ALL_SEEN = '1;

   logic [SEG_W-1:0]      seg_s;
   logic [NUM_DIGITS-1:0] sel_s;
   scan_t                 cur, prev;
   logic                  changed_c;
   logic [SCNT_W-1:0]     scnt;
   logic [TCNT_W-1:0]     tcnt;
   state_t                state, state_n;
   logic                  cap_c, cap_ok_c, cap_pat_c, cap_sel_c, timeout_c;
   logic [NIB_W:0]        dec_c;
   logic [NUM_DIGITS-1:0] seen, seen_n, valid_n;
   logic [DIG_W-1:0]      digits_n;

   d7s_scan_decoder_sync2 #(.WIDTH(SEG_W)) u_sync_seg (
      .clk (clk), .rst (rst), .d (seg_in), .q (seg_s)
   );

   d7s_scan_decoder_sync2 #(.WIDTH(NUM_DIGITS)) u_sync_sel (
      .clk (clk), .rst (rst), .d (dig_sel_in), .q (sel_s)
   );

   assign cur       = {sel_s, seg_s};
   assign changed_c = (cur != prev);

   // Stability counter: the capture fires on the edge it would reach STABLE_CYCLES
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         prev <= '0;
         scnt <= '0;
      end else begin
         prev <= cur;
         if (changed_c)
            scnt <= '0;
         else if (scnt != SCNT_MAX)
            scnt <= scnt + SCNT_W'(1);
      end
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) state <= SETTLE;
      else     state <= state_n;
   end

   always_comb begin
      state_n = state;
      cap_c   = 1'b0;
      case (state)
         SETTLE: if (!changed_c && scnt == SCNT_HIT) begin
            cap_c   = 1'b1;
            state_n = HELD;
         end
         HELD:   if (changed_c) state_n = SETTLE;
         default: state_n = SETTLE;
      endcase
   end

   assign dec_c     = seg2nib(cur.seg);
   assign cap_ok_c  = cap_c && $onehot(cur.sel) && dec_c[NIB_W];
   assign cap_pat_c = cap_c && $onehot(cur.sel) && !dec_c[NIB_W];
   assign cap_sel_c = cap_c && (cur.sel != '0) && !$onehot(cur.sel);
   assign timeout_c = !cap_ok_c && (tcnt == TCNT_HIT);

   // Next digit/valid/seen; a completed frame restarts seen before this edge's capture
   always_comb begin
      digits_n = digits;
      valid_n  = digit_valid;
      seen_n   = (seen == ALL_SEEN) ? '0 : seen;
      if (cap_ok_c) begin
         for (int unsigned i = 0; i < NUM_DIGITS; i++)
            if (cur.sel[i]) digits_n[NIB_W*i +: NIB_W] = dec_c[NIB_W-1:0];
         valid_n = valid_n | cur.sel;
         seen_n  = seen_n | cur.sel;
      end
      if (timeout_c) begin
         valid_n = '0;
         seen_n  = '0;
      end
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         tcnt        <= '0;
         seen        <= '0;
         digits      <= '0;
         digit_valid <= '0;
         frame_done  <= 1'b0;
         pattern_err <= 1'b0;
         sel_err     <= 1'b0;
         link_lost   <= 1'b0;
      end else begin
         seen        <= seen_n;
         digits      <= digits_n;
         digit_valid <= valid_n;
         frame_done  <= (seen == ALL_SEEN);
         pattern_err <= (pattern_err && !err_clr) || cap_pat_c;
         sel_err     <= (sel_err && !err_clr) || cap_sel_c;
         if (cap_ok_c)
            tcnt <= '0;
         else if (tcnt != TCNT_MAX)
            tcnt <= tcnt + TCNT_W'(1);
         if (cap_ok_c)
            link_lost <= 1'b0;
         else if (timeout_c)
            link_lost <= 1'b1;
      end
   end

endmodule

// File: tb/tb_d7s_scan_decoder.sv
// Randomized and directed bench for d7s_scan_decoder against a sample-history
// reference model; a second instance exercises STABLE_CYCLES=1.
module tb_d7s_scan_decoder;

   localparam int S = 4;
   localparam int T = 64;

   logic        clk = 1'b0;
   logic        rst = 1'b1;
   logic [6:0]  seg = '0;
   logic [2:0]  sel = '0;
   logic        err_clr = 1'b0;
   logic [11:0] digits;
   logic [2:0]  digit_valid;
   logic        frame_done, pattern_err, sel_err, link_lost;

   logic [6:0]  seg1 = '0;
   logic [2:0]  sel1 = '0;
   logic        err_clr1 = 1'b0;
   logic [11:0] digits1;
   logic [2:0]  digit_valid1;
   logic        frame_done1, pattern_err1, sel_err1, link_lost1;

   int n_checks = 0;
   int n_fail   = 0;
   int fd_cnt   = 0;
   int fd1_cnt  = 0;

   always #5 clk = ~clk;

   d7s_scan_decoder #(.STABLE_CYCLES(S), .TIMEOUT_CYCLES(T)) dut (
      .clk(clk), .rst(rst), .seg_in(seg), .dig_sel_in(sel), .err_clr(err_clr),
      .digits(digits), .digit_valid(digit_valid), .frame_done(frame_done),
      .pattern_err(pattern_err), .sel_err(sel_err), .link_lost(link_lost)
   );

   d7s_scan_decoder #(.STABLE_CYCLES(1), .TIMEOUT_CYCLES(T)) dut1 (
      .clk(clk), .rst(rst), .seg_in(seg1), .dig_sel_in(sel1), .err_clr(err_clr1),
      .digits(digits1), .digit_valid(digit_valid1), .frame_done(frame_done1),
      .pattern_err(pattern_err1), .sel_err(sel_err1), .link_lost(link_lost1)
   );

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_checks++;
      if (got !== exp) begin
         n_fail++;
         $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
      end
   endtask

   // Reference segment table, index = displayed value
   logic [6:0] codes [16] = '{7'h3F, 7'h06, 7'h5B, 7'h4F, 7'h66, 7'h6D, 7'h7D, 7'h07,
                              7'h7F, 7'h6F, 7'h77, 7'h7C, 7'h39, 7'h5E, 7'h79, 7'h71};

   function automatic int decode(input logic [6:0] s);
      decode = -1;
      for (int i = 0; i < 16; i++) if (codes[i] == s) decode = i;
   endfunction

   // Model: a value is acted on when it has been seen S+1 samples in a row,
   // two samples behind the pins; run length saturates so it fires once.
   logic [9:0]  p1, p2, last_d;
   int          run;
   logic [11:0] m_digits;
   logic [2:0]  m_valid, m_seen;
   logic        m_fd, m_perr, m_serr, m_link;
   int          m_tcnt;

   always @(posedge clk or posedge rst) begin : model
      logic [9:0] d;
      logic       ok, fd_n, pset, sset;
      int         idx, slot;
      if (rst) begin
         p1 = '0; p2 = '0; last_d = '0; run = 1;
         m_digits = '0; m_valid = '0; m_seen = '0;
         m_fd = 0; m_perr = 0; m_serr = 0; m_link = 0; m_tcnt = 0;
      end else begin
         d = p2;
         if (d == last_d) begin
            if (run < S + 2) run++;
         end else run = 1;
         last_d = d;
         ok = 0; pset = 0; sset = 0; slot = 0;
         fd_n = (m_seen == 3'b111);
         if (fd_n) m_seen = '0;
         if (run == S + 1 && d[9:7] != 3'b000) begin
            if ($countones(d[9:7]) == 1) begin
               idx = decode(d[6:0]);
               for (int i = 0; i < 3; i++) if (d[7+i]) slot = i;
               if (idx >= 0) begin
                  m_digits[slot*4 +: 4] = 4'(idx);
                  m_valid[slot] = 1'b1;
                  m_seen[slot]  = 1'b1;
                  ok = 1;
               end else pset = 1;
            end else sset = 1;
         end
         if (err_clr) begin m_perr = 0; m_serr = 0; end
         if (pset) m_perr = 1;
         if (sset) m_serr = 1;
         if (ok) begin
            m_tcnt = 0; m_link = 0;
         end else if (m_tcnt < T) begin
            m_tcnt++;
            if (m_tcnt == T) begin m_link = 1; m_valid = '0; m_seen = '0; end
         end
         m_fd = fd_n;
         p2 = p1;
         p1 = {sel, seg};
      end
   end

   always @(negedge clk) begin
      if (frame_done)  fd_cnt++;
      if (frame_done1) fd1_cnt++;
      check("m_digits", 32'(digits), 32'(m_digits));
      check("m_valid", 32'(digit_valid), 32'(m_valid));
      check("m_frame_done", 32'(frame_done), 32'(m_fd));
      check("m_pattern_err", 32'(pattern_err), 32'(m_perr));
      check("m_sel_err", 32'(sel_err), 32'(m_serr));
      check("m_link_lost", 32'(link_lost), 32'(m_link));
   end

   task automatic hold(input logic [2:0] s, input logic [6:0] g, input int n);
      sel = s; seg = g;
      repeat (n) @(negedge clk);
   endtask

   task automatic check_zero(input string tag);
      check({tag, "_digits"}, 32'(digits), 0);
      check({tag, "_valid"}, 32'(digit_valid), 0);
      check({tag, "_fd"}, 32'(frame_done), 0);
      check({tag, "_perr"}, 32'(pattern_err), 0);
      check({tag, "_serr"}, 32'(sel_err), 0);
      check({tag, "_link"}, 32'(link_lost), 0);
   endtask

   initial begin
      #500000;
      $display("FAIL watchdog: simulation time limit reached, %0d checks", n_checks);
      $fatal(1, "watchdog");
   end

   initial begin : stim
      int f0, len, r;
      logic [2:0] rs;
      logic [6:0] rg;
      repeat (3) @(negedge clk);
      check_zero("reset");
      rst = 1'b0;

      // Full frame scan, twice
      f0 = fd_cnt;
      for (int k = 0; k < 2; k++) begin
         hold(3'b001, 7'h06, 10); hold(3'b000, 7'h00, 2);
         hold(3'b010, 7'h5B, 10); hold(3'b000, 7'h00, 2);
         hold(3'b100, 7'h71, 10); hold(3'b000, 7'h00, 2);
         check("frame_digits", 32'(digits), 32'h0F21);
         check("frame_valid", 32'(digit_valid), 32'h7);
         check("frame_pulses", 32'(fd_cnt - f0), 32'(k + 1));
      end

      // Reset mid-frame, then first-capture latency
      hold(3'b001, 7'h3F, 10);
      hold(3'b010, 7'h4F, 3);
      #2 rst = 1'b1;
      #1 check_zero("mid_reset");
      @(negedge clk); @(negedge clk);
      rst = 1'b0;
      sel = 3'b001; seg = 7'h4F;
      repeat (6) @(negedge clk);
      check("lat_before_valid", 32'(digit_valid), 0);
      @(negedge clk);
      check("lat_valid", 32'(digit_valid), 32'h1);
      check("lat_digits", 32'(digits), 32'h003);

      // Glitch rejection
      for (int k = 0; k < 8; k++) hold(3'b001, (k % 2 == 0) ? 7'h3F : 7'h06, 3);
      check("glitch_digits", 32'(digits), 32'h003);
      hold(3'b001, 7'h06, 10);
      check("glitch_settled", 32'(digits), 32'h001);

      // Error flags
      hold(3'b010, 7'h00, 10);
      check("perr_set", 32'(pattern_err), 1);
      check("perr_digits", 32'(digits), 32'h001);
      hold(3'b000, 7'h00, 2);
      hold(3'b011, 7'h06, 10);
      check("serr_set", 32'(sel_err), 1);
      check("serr_digits", 32'(digits), 32'h001);
      sel = 3'b010; seg = 7'h01;
      repeat (6) @(negedge clk);
      err_clr = 1'b1;
      @(negedge clk);
      err_clr = 1'b0;
      check("clr_vs_set_perr", 32'(pattern_err), 1);
      check("clr_vs_set_serr", 32'(sel_err), 0);
      repeat (3) @(negedge clk);
      err_clr = 1'b1;
      @(negedge clk);
      err_clr = 1'b0;
      check("clr_perr", 32'(pattern_err), 0);
      check("clr_serr", 32'(sel_err), 0);

      // Randomized scanning against the model
      for (int k = 0; k < 300; k++) begin
         r = $urandom_range(0, 9);
         if (r < 2)      rs = 3'b000;
         else if (r < 9) rs = 3'(1 << (r % 3));
         else            rs = ($urandom_range(0, 1) == 0) ? 3'b111 : 3'b101;
         rg = ($urandom_range(0, 19) < 17) ? codes[$urandom_range(0, 15)] : 7'($urandom_range(0, 127));
         len = $urandom_range(1, 12);
         sel = rs; seg = rg;
         repeat (len) begin
            err_clr = ($urandom_range(0, 19) == 0);
            @(negedge clk);
         end
         err_clr = 1'b0;
      end

      // Timeout after a full frame, then recovery
      hold(3'b001, 7'h79, 10); hold(3'b000, 7'h00, 2);
      hold(3'b010, 7'h39, 10); hold(3'b000, 7'h00, 2);
      hold(3'b100, 7'h5E, 10);
      hold(3'b000, 7'h00, 60);
      check("to_not_yet", 32'(link_lost), 0);
      hold(3'b000, 7'h00, 1);
      check("to_link", 32'(link_lost), 1);
      check("to_valid", 32'(digit_valid), 0);
      check("to_digits", 32'(digits), 32'hDCE);
      hold(3'b001, 7'h7F, 10);
      check("resume_link", 32'(link_lost), 0);
      check("resume_valid", 32'(digit_valid), 32'h1);
      check("resume_digits", 32'(digits), 32'hDC8);

      // STABLE_CYCLES=1 instance
      sel1 = 3'b001; seg1 = 7'h6D;
      repeat (3) @(negedge clk);
      check("s1_before", 32'(digit_valid1), 0);
      @(negedge clk);
      check("s1_valid", 32'(digit_valid1), 32'h1);
      check("s1_digit", 32'(digits1[3:0]), 32'h5);
      check("s1_link", 32'(link_lost1), 0);
      sel1 = 3'b010; seg1 = 7'h66;
      repeat (5) @(negedge clk);
      f0 = fd1_cnt;
      sel1 = 3'b100; seg1 = 7'h6F;
      repeat (100) @(negedge clk);
      check("s1_one_pulse", 32'(fd1_cnt - f0), 1);
      check("s1_digits", 32'(digits1), 32'h945);
      check("s1_held_timeout", 32'(link_lost1), 1);
      check("s1_held_valid", 32'(digit_valid1), 0);

      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule
